// File: rtl/sdram_pixel_prefetch_pkg.sv
// Shared definitions for the SDRAM read-side pixel prefetch buffer:
// FSM encoding, default geometry, and a constant-friendly clog2.
package sdram_pixel_prefetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FILL  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;
  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int BURST_LEN    = 8;
  localparam int PIXEL_W      = 16;
  localparam int FIFO_DEPTH   = 64;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return clog2_ret(result);
  endfunction

  function automatic int clog2_ret(input int r);
    return r;
  endfunction

endpackage

// File: rtl/sdram_pixel_prefetch_if.sv
// Bus bundle between the prefetch buffer, the SDRAM facade and the pixel consumer.
// master = the prefetch block, slave = the environment driving facade/consumer inputs.
interface sdram_pixel_prefetch_if #(
  parameter int PBW = 16,
  parameter int LW  = 7
);
  logic           o_read_req;
  logic           i_busy_rd;
  logic [PBW-1:0] i_pixel;
  logic           i_ready;
  logic           i_frame_start;
  logic           i_pix_req;
  logic [PBW-1:0] o_pixel;
  logic           o_pixel_valid;
  logic [LW-1:0]  o_level;
  logic           o_underflow;
  logic           o_overflow;

  modport master (
    output o_read_req, o_pixel, o_pixel_valid, o_level, o_underflow, o_overflow,
    input  i_busy_rd, i_pixel, i_ready, i_frame_start, i_pix_req
  );

  modport slave (
    input  o_read_req, o_pixel, o_pixel_valid, o_level, o_underflow, o_overflow,
    output i_busy_rd, i_pixel, i_ready, i_frame_start, i_pix_req
  );
endinterface

// File: rtl/sdram_pixel_prefetch_fifo.sv
// Single-clock pixel FIFO with block-RAM storage, registered read data and
// a synchronous clear; occupancy is the difference of two wrap counters.
module pixel_fifo_sync
  import sdram_pixel_prefetch_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [clog2(DEPTH):0]    level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_cnt_reg;
  logic [AW:0]   rd_cnt_reg;
  logic [W-1:0]  rd_data_reg;
  logic          do_push;
  logic          do_pop;

  assign level   = wr_cnt_reg - rd_cnt_reg;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty;
  assign rd_data = rd_data_reg;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_cnt_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_reg <= '0;
    end else if (do_pop) begin
      rd_data_reg <= mem[rd_cnt_reg[AW-1:0]];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
    end else begin
      if (do_push) wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (do_pop)  rd_cnt_reg <= rd_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_pixel_prefetch.sv
// Read-side prefetch between the SDRAM facade and scan-out: credit-gated burst
// requests fill a FIFO that serves one pixel per consumer request, 1-cycle latency.
module sdram_pixel_prefetch
  import sdram_pixel_prefetch_pkg::*;
#(
  parameter int FrameWidth       = FRAME_WIDTH,
  parameter int FrameHeight      = FRAME_HEIGHT,
  parameter int BurstLengthSDRAM = BURST_LEN,
  parameter int PixelBitWidth    = PIXEL_W,
  parameter int FifoDepth        = FIFO_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  sdram_pixel_prefetch_if.master bus
);
  localparam int FramePixels = FrameWidth * FrameHeight;
  localparam int FCW         = clog2(FramePixels + 1);
  localparam int LW          = clog2(FifoDepth) + 1;
  localparam int IW          = clog2(BurstLengthSDRAM + 1);

  fetch_state_t           state_reg, state_next;
  logic [IW-1:0]          inflight_reg, inflight_next;
  logic [FCW-1:0]         fetched_reg, fetched_next;
  logic                   underflow_reg, underflow_next;
  logic                   overflow_reg, overflow_next;
  logic                   valid_reg;
  logic                   black_reg;

  logic                   fifo_push, fifo_pop, fifo_clear;
  logic                   fifo_full, fifo_empty;
  logic [LW-1:0]          fifo_level;
  logic [PixelBitWidth-1:0] fifo_rd_data;
  logic [LW:0]            free_space;
  logic                   credit_ok;
  logic                   frame_done;

  // Beats already promised by an accepted burst count against free space.
  assign free_space = (LW+1)'(FifoDepth) - {1'b0, fifo_level} - (LW+1)'(inflight_reg);
  assign credit_ok  = free_space >= (LW+1)'(BurstLengthSDRAM);
  assign frame_done = fetched_reg >= FCW'(FramePixels);
  assign fifo_pop   = bus.i_pix_req && !fifo_empty;

  always_comb begin
    state_next     = state_reg;
    inflight_next  = inflight_reg;
    fetched_next   = fetched_reg;
    underflow_next = underflow_reg;
    overflow_next  = overflow_reg;
    fifo_push      = 1'b0;
    fifo_clear     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (credit_ok && !frame_done) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (bus.i_busy_rd) begin
          state_next    = ST_FILL;
          inflight_next = IW'(BurstLengthSDRAM);
        end
      end
      ST_FILL: begin
        if (bus.i_ready) begin
          fifo_push     = 1'b1;
          inflight_next = inflight_reg - 1'b1;
          if (!frame_done) fetched_next = fetched_reg + 1'b1;
          if (inflight_reg == IW'(1)) state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (bus.i_ready) begin
          inflight_next = inflight_reg - 1'b1;
          if (inflight_reg == IW'(1)) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (fifo_push && fifo_full) overflow_next = 1'b1;
    if (bus.i_pix_req && fifo_empty) underflow_next = 1'b1;

    // A new frame wins over everything; a burst accepted this very cycle is drained unseen.
    if (bus.i_frame_start) begin
      fifo_clear     = 1'b1;
      fifo_push      = 1'b0;
      fetched_next   = '0;
      underflow_next = 1'b0;
      overflow_next  = 1'b0;
      state_next     = (inflight_next == '0) ? ST_IDLE : ST_FLUSH;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      inflight_reg  <= '0;
      fetched_reg   <= '0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      valid_reg     <= 1'b0;
      black_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      inflight_reg  <= inflight_next;
      fetched_reg   <= fetched_next;
      underflow_reg <= underflow_next;
      overflow_reg  <= overflow_next;
      valid_reg     <= fifo_pop;
      if (bus.i_pix_req) black_reg <= fifo_empty;
    end
  end

  pixel_fifo_sync #(
    .W     (PixelBitWidth),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .clear   (fifo_clear),
    .wr_data (bus.i_pixel),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.o_read_req    = (state_reg == ST_REQ);
  assign bus.o_pixel       = black_reg ? PixelBitWidth'(RGB565_BLACK) : fifo_rd_data;
  assign bus.o_pixel_valid = valid_reg;
  assign bus.o_level       = fifo_level;
  assign bus.o_underflow   = underflow_reg;
  assign bus.o_overflow    = overflow_reg;

endmodule

// File: tb/tb_sdram_pixel_prefetch.sv
// Bench for sdram_pixel_prefetch: plays the SDRAM facade and the consumer, keeps a
// queue-based reference of FIFO contents, credits and frame fetch count.
module tb_sdram_pixel_prefetch;
  localparam int FW    = 16;
  localparam int FH    = 8;
  localparam int FRAME = FW * FH;
  localparam int BL    = 8;
  localparam int DEPTH = 64;
  localparam int PBW   = 16;
  localparam int LW    = 7;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sdram_pixel_prefetch_if #(.PBW(PBW), .LW(LW)) bus_if();

  sdram_pixel_prefetch #(
    .FrameWidth       (FW),
    .FrameHeight      (FH),
    .BurstLengthSDRAM (BL),
    .PixelBitWidth    (PBW),
    .FifoDepth        (DEPTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (as it must be after the most recent clock edge).
  logic [PBW-1:0] m_q[$];
  int             m_inflight = 0;
  int             m_discard  = 0;
  int             m_fetched  = 0;
  bit             m_under    = 1'b0;
  logic [PBW-1:0] m_pix      = '0;
  bit             m_valid    = 1'b0;
  bit             m_fs_last  = 1'b0;
  int             bursts_total = 0;
  int             bursts_frame = 0;
  bit             chk_en = 1'b0;
  bit             prev_elig = 1'b0;

  int             acc_pct  = 100;
  int             beat_pct = 100;
  bit             seq_mode = 1'b1;
  logic [PBW-1:0] seq_val  = 16'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit eligible();
    return (m_inflight == 0) && ((DEPTH - m_q.size()) >= BL) && (m_fetched < FRAME);
  endfunction

  // Per-cycle comparison of every output against the reference.
  always @(negedge CLK) begin
    if (chk_en) begin
      bit el;
      el = eligible();
      check("level",     32'(bus_if.o_level), 32'(m_q.size()));
      check("valid",     32'(bus_if.o_pixel_valid), 32'(m_valid));
      check("pixel",     32'(bus_if.o_pixel), 32'(m_pix));
      check("underflow", 32'(bus_if.o_underflow), 32'(m_under));
      check("overflow",  32'(bus_if.o_overflow), 32'd0);
      check("req_guard", 32'(bus_if.o_read_req && !el), 32'd0);
      if (prev_elig && el && !m_fs_last) check("req_live", 32'(bus_if.o_read_req), 32'd1);
      prev_elig = el;
    end
  end

  // One clock: decide facade/consumer inputs from current outputs, advance the model.
  task automatic step(input bit fs, input bit pr);
    logic rdy, acc, busy;
    logic [PBW-1:0] px;
    rdy  = (m_inflight > 0) && ($urandom_range(99) < beat_pct);
    px   = seq_mode ? seq_val : PBW'($urandom);
    acc  = bus_if.o_read_req && ($urandom_range(99) < acc_pct);
    busy = acc || (m_inflight > 0);
    bus_if.i_ready       = rdy;
    bus_if.i_pixel       = px;
    bus_if.i_busy_rd     = busy;
    bus_if.i_frame_start = fs;
    bus_if.i_pix_req     = pr;

    if (pr) begin
      if (m_q.size() > 0) begin
        m_pix   = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_pix   = '0;
        m_valid = 1'b0;
        m_under = 1'b1;
      end
    end else begin
      m_valid = 1'b0;
    end
    if (rdy) begin
      m_inflight--;
      if (m_discard > 0) m_discard--;
      else if (!fs) begin
        m_q.push_back(px);
        if (m_fetched < FRAME) m_fetched++;
      end
      if (seq_mode) seq_val++;
    end
    if (acc) begin
      m_inflight = BL;
      bursts_total++;
      bursts_frame++;
    end
    if (fs) begin
      m_q.delete();
      m_fetched    = 0;
      m_under      = 1'b0;
      m_discard    = m_inflight;
      bursts_frame = 0;
    end
    m_fs_last = fs;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int snap;
    bus_if.i_ready       = 1'b0;
    bus_if.i_pixel       = '0;
    bus_if.i_busy_rd     = 1'b0;
    bus_if.i_frame_start = 1'b0;
    bus_if.i_pix_req     = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_req",   32'(bus_if.o_read_req), 32'd0);
    check("rst_level", 32'(bus_if.o_level), 32'd0);
    check("rst_valid", 32'(bus_if.o_pixel_valid), 32'd0);
    check("rst_pixel", 32'(bus_if.o_pixel), 32'd0);
    check("rst_under", 32'(bus_if.o_underflow), 32'd0);
    check("rst_over",  32'(bus_if.o_overflow), 32'd0);
    bus_if.i_pix_req = 1'b0;
    RST    = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);
    #1;
    check("req_after_reset", 32'(bus_if.o_read_req), 32'd1);

    // First burst 0x0001..0x0008, then the next request must follow.
    step(0, 0);
    acc_pct = 0;
    repeat (8) step(0, 0);
    check("burst1_level", 32'(bus_if.o_level), 32'd8);
    check("burst1_idle",  32'(bus_if.o_read_req), 32'd0);
    step(0, 0);
    check("second_req",   32'(bus_if.o_read_req), 32'd1);

    // No consumer: fetching must stop exactly at a full FIFO.
    acc_pct = 100;
    repeat (150) step(0, 0);
    check("full_level",  32'(bus_if.o_level), 32'd64);
    check("full_bursts", 32'(bursts_total), 32'd8);
    check("full_noreq",  32'(bus_if.o_read_req), 32'd0);

    // New frame, one burst, then 9 pops: 8 pixels then a black underflow filler.
    seq_val = 16'd1;
    step(1, 0);
    for (int k = 0; k < 10 && bursts_frame == 0; k++) step(0, 0);
    check("refill_accept", 32'(bursts_frame), 32'd1);
    acc_pct = 0;
    for (int k = 0; k < 20 && m_inflight > 0; k++) step(0, 0);
    check("refill_level", 32'(bus_if.o_level), 32'd8);
    for (int i = 0; i < 9; i++) begin
      step(0, 1);
      if (i < 8) begin
        check("drain_pixel", 32'(bus_if.o_pixel), 32'(i + 1));
        check("drain_valid", 32'(bus_if.o_pixel_valid), 32'd1);
      end else begin
        check("uf_pixel", 32'(bus_if.o_pixel), 32'd0);
        check("uf_valid", 32'(bus_if.o_pixel_valid), 32'd0);
        check("uf_flag",  32'(bus_if.o_underflow), 32'd1);
      end
    end

    // Frame start on the 4th beat of a burst: beats 4..8 are dropped.
    seq_val = 16'd1;
    acc_pct = 100;
    snap = bursts_total;
    for (int k = 0; k < 10 && bursts_total == snap; k++) step(0, 0);
    acc_pct = 0;
    repeat (3) step(0, 0);
    check("pre_flush_level", 32'(bus_if.o_level), 32'd3);
    step(1, 0);
    for (int k = 0; k < 20 && m_inflight > 0; k++) step(0, 0);
    check("flush_level", 32'(bus_if.o_level), 32'd0);
    check("flush_under", 32'(bus_if.o_underflow), 32'd0);
    check("flush_noreq", 32'(bus_if.o_read_req), 32'd0);
    step(0, 0);
    check("flush_req",   32'(bus_if.o_read_req), 32'd1);

    // Frame-size limit: after FRAME pixels, no more requests until the next frame.
    seq_mode = 1'b0;
    acc_pct  = 100;
    step(1, 0);
    repeat (400) step(0, 1);
    check("frame_bursts", 32'(bursts_frame), 32'(FRAME / BL));
    check("frame_noreq",  32'(bus_if.o_read_req), 32'd0);
    step(1, 0);
    for (int k = 0; k < 5 && bursts_frame == 0; k++) step(0, 0);
    check("frame_restart", 32'(bursts_frame > 0), 32'd1);

    // Randomized traffic: stalls, uneven beats, consumer bursts and frame restarts.
    acc_pct  = 50;
    beat_pct = 70;
    for (int blk = 0; blk < 6; blk++) begin
      int pr_pct;
      pr_pct = int'($urandom_range(90, 10));
      for (int c = 0; c < 500; c++) begin
        bit fs, pr;
        fs = ($urandom_range(999) < 3);
        pr = !fs && ($urandom_range(99) < pr_pct);
        step(fs, pr);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
